ff_seq_checker: RTL and testbench

// - Receive-side checker for the 8-bit flip-flop data path.
// - Samples the registered output stream (qout) and locks onto the first valid word.
// - Checks that each later valid word equals the previous word + STEP, modulo 2^WIDTH.
// - Reports match/error counts and completion. Sits after the DUV, on the same clk.

---
 rtl/ff_seq_checker.sv | 179 +++++++++++++++++
 tb/tb_ff_seq_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ff_seq_checker.sv
// Receive-side sequence checker for the flip-flop data path.
// Locks onto the first valid word after start, then checks that each later
// valid word equals the previous word plus STEP (modulo 2^WIDTH). Keeps
// saturating match/error counts, flags mismatches and signals completion.
// Every output comes straight from a flop.
module ff_seq_checker #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned STEP    = 1,
   parameter int unsigned SEQ_LEN = 7,
   parameter int unsigned MAX_ERR = 3,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             valid,
   input  logic [WIDTH-1:0] qout,
   output logic             locked,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH-1:0] expected,
   output logic             done
);

   localparam int unsigned ConsecW = (MAX_ERR < 2) ? 1 : $clog2(MAX_ERR + 1);

   localparam logic [WIDTH-1:0]   StepC   = WIDTH'(STEP);
   localparam logic [CNT_W-1:0]   SeqLenC = CNT_W'(SEQ_LEN);
   localparam logic [ConsecW-1:0] MaxErrC = ConsecW'(MAX_ERR);

   typedef enum logic [1:0] {
      StIdle,
      StSync,
      StCheck,
      StDone
   } state_e;

   state_e             state_q, state_d;
   logic               locked_q, locked_d;
   logic               err_q, err_d;
   logic               err_sticky_q, err_sticky_d;
   logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0]   expected_q, expected_d;
   logic               done_q, done_d;
   logic [ConsecW-1:0] consec_q, consec_d;

   // Saturating increments and the wrapped follow-on values.
   logic [CNT_W-1:0]   match_cnt_inc;
   logic [CNT_W-1:0]   err_cnt_inc;
   logic [ConsecW-1:0] consec_inc;
   logic [WIDTH-1:0]   qout_next;
   logic [WIDTH-1:0]   expected_next;
   logic               word_ok;

   // Arithmetic helpers shared by the next-state logic.
   always_comb begin
      match_cnt_inc = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + 1'b1;
      err_cnt_inc   = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
      consec_inc    = consec_q + 1'b1;
      qout_next     = qout + StepC;
      expected_next = expected_q + StepC;
      word_ok       = (qout == expected_q);
   end

   // Next-state and next-output computation for the checker FSM.
   always_comb begin
      state_d      = state_q;
      locked_d     = locked_q;
      err_d        = 1'b0;
      err_sticky_d = err_sticky_q;
      match_cnt_d  = match_cnt_q;
      err_cnt_d    = err_cnt_q;
      expected_d   = expected_q;
      done_d       = done_q;
      consec_d     = consec_q;

      if (start) begin
         // start wins over valid; a word presented alongside it is dropped.
         state_d      = StSync;
         locked_d     = 1'b0;
         err_sticky_d = 1'b0;
         match_cnt_d  = '0;
         err_cnt_d    = '0;
         done_d       = 1'b0;
         consec_d     = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // Waiting for start; valid words are ignored.
            end

            StSync: begin
               if (valid) begin
                  // Seed word: not counted, only primes the expectation.
                  expected_d = qout_next;
                  locked_d   = 1'b1;
                  state_d    = StCheck;
               end
            end

            StCheck: begin
               if (valid) begin
                  if (word_ok) begin
                     match_cnt_d = match_cnt_inc;
                     consec_d    = '0;
                     expected_d  = qout_next;
                     if (match_cnt_inc == SeqLenC) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                     end
                  end else begin
                     err_d        = 1'b1;
                     err_sticky_d = 1'b1;
                     err_cnt_d    = err_cnt_inc;
                     // Advance along the expected sequence rather than re-seed,
                     // so an isolated corrupt word costs exactly one error.
                     expected_d   = expected_next;
                     if (consec_inc == MaxErrC) begin
                        state_d  = StSync;
                        locked_d = 1'b0;
                        consec_d = '0;
                     end else begin
                        consec_d = consec_inc;
                     end
                  end
               end
            end

            StDone: begin
               // Counters frozen until the next start.
            end

            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
         match_cnt_q  <= '0;
         err_cnt_q    <= '0;
         expected_q   <= '0;
         done_q       <= 1'b0;
         consec_q     <= '0;
      end else begin
         state_q      <= state_d;
         locked_q     <= locked_d;
         err_q        <= err_d;
         err_sticky_q <= err_sticky_d;
         match_cnt_q  <= match_cnt_d;
         err_cnt_q    <= err_cnt_d;
         expected_q   <= expected_d;
         done_q       <= done_d;
         consec_q     <= consec_d;
      end
   end

   // Outputs are driven directly from flops.
   always_comb begin
      locked     = locked_q;
      err        = err_q;
      err_sticky = err_sticky_q;
      match_cnt  = match_cnt_q;
      err_cnt    = err_cnt_q;
      expected   = expected_q;
      done       = done_q;
   end

endmodule

// File: tb/tb_ff_seq_checker.sv
// Self-checking bench for ff_seq_checker: table of stimulus/expected records
// plus a hand-written asynchronous-reset sequence, checked via a scoreboard.
module tb_ff_seq_checker;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic       valid;
   logic [7:0] qout;
   logic       locked;
   logic       err;
   logic       err_sticky;
   logic [7:0] match_cnt;
   logic [7:0] err_cnt;
   logic [7:0] expected;
   logic       done;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic       st;
      logic       vl;
      logic [7:0] q;
      logic       lk;
      logic       er;
      logic       es;
      logic [7:0] mc;
      logic [7:0] ec;
      logic [7:0] ex;
      logic       dn;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   ff_seq_checker #(
      .WIDTH  (8),
      .STEP   (1),
      .SEQ_LEN(7),
      .MAX_ERR(3),
      .CNT_W  (8)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .valid     (valid),
      .qout      (qout),
      .locked    (locked),
      .err       (err),
      .err_sticky(err_sticky),
      .match_cnt (match_cnt),
      .err_cnt   (err_cnt),
      .expected  (expected),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t mk(input logic st, input logic vl, input logic [7:0] q,
                               input logic lk, input logic er, input logic es,
                               input logic [7:0] mc, input logic [7:0] ec,
                               input logic [7:0] ex, input logic dn);
      vec_t v;
      v.st = st; v.vl = vl; v.q = q;
      v.lk = lk; v.er = er; v.es = es;
      v.mc = mc; v.ec = ec; v.ex = ex; v.dn = dn;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s [step %0d]: actual=%0h required=%0h", name, idx, act, req);
      end
   endtask

   task automatic chk_all(input int idx, input vec_t e);
      chk("locked", idx, 32'(locked), 32'(e.lk));
      chk("err", idx, 32'(err), 32'(e.er));
      chk("err_sticky", idx, 32'(err_sticky), 32'(e.es));
      chk("match_cnt", idx, 32'(match_cnt), 32'(e.mc));
      chk("err_cnt", idx, 32'(err_cnt), 32'(e.ec));
      chk("expected", idx, 32'(expected), 32'(e.ex));
      chk("done", idx, 32'(done), 32'(e.dn));
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic apply(input int idx, input vec_t v);
      vec_t e;
      @(negedge clk);
      start = v.st;
      valid = v.vl;
      qout  = v.q;
      sb.push_back(v);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard [step %0d]: actual=empty required=entry", idx);
      end else begin
         e = sb.pop_front();
         chk_all(idx, e);
      end
   endtask

   initial begin
      vec_t z;
      n_cmp   = 0;
      n_bad   = 0;
      reset_n = 1'b0;
      start   = 1'b0;
      valid   = 1'b0;
      qout    = 8'h00;

      // Happy path: seed 0 then 1..7 completes the run.
      vecs.push_back(mk(1, 0, 8'd0,  0, 0, 0, 0, 0, 8'd0, 0));
      vecs.push_back(mk(0, 1, 8'd0,  1, 0, 0, 0, 0, 8'd1, 0));
      for (int k = 1; k <= 7; k++)
         vecs.push_back(mk(0, 1, 8'(k), 1, 0, 0, 8'(k), 0, 8'(k + 1), (k == 7)));
      vecs.push_back(mk(0, 1, 8'd99, 1, 0, 0, 7, 0, 8'd8, 1));
      vecs.push_back(mk(0, 0, 8'd0,  1, 0, 0, 7, 0, 8'd8, 1));
      // Single error: seed 10, then 11,12,99,14.
      vecs.push_back(mk(1, 0, 8'd0,  0, 0, 0, 0, 0, 8'd8,  0));
      vecs.push_back(mk(0, 1, 8'd10, 1, 0, 0, 0, 0, 8'd11, 0));
      vecs.push_back(mk(0, 1, 8'd11, 1, 0, 0, 1, 0, 8'd12, 0));
      vecs.push_back(mk(0, 1, 8'd12, 1, 0, 0, 2, 0, 8'd13, 0));
      vecs.push_back(mk(0, 1, 8'd99, 1, 1, 1, 2, 1, 8'd14, 0));
      vecs.push_back(mk(0, 1, 8'd14, 1, 0, 1, 3, 1, 8'd15, 0));
      vecs.push_back(mk(0, 0, 8'd77, 1, 0, 1, 3, 1, 8'd15, 0));
      // Resync after three consecutive misses.
      vecs.push_back(mk(1, 0, 8'd0,  0, 0, 0, 0, 0, 8'd15, 0));
      vecs.push_back(mk(0, 1, 8'd0,  1, 0, 0, 0, 0, 8'd1,  0));
      vecs.push_back(mk(0, 1, 8'd50, 1, 1, 1, 0, 1, 8'd2,  0));
      vecs.push_back(mk(0, 1, 8'd60, 1, 1, 1, 0, 2, 8'd3,  0));
      vecs.push_back(mk(0, 1, 8'd70, 0, 1, 1, 0, 3, 8'd4,  0));
      vecs.push_back(mk(0, 1, 8'd80, 1, 0, 1, 0, 3, 8'd81, 0));
      vecs.push_back(mk(0, 1, 8'd81, 1, 0, 1, 1, 3, 8'd82, 0));
      // Wrap through 8'hFF.
      vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'd82,  0));
      vecs.push_back(mk(0, 1, 8'hFD, 1, 0, 0, 0, 0, 8'hFE, 0));
      vecs.push_back(mk(0, 1, 8'hFE, 1, 0, 0, 1, 0, 8'hFF, 0));
      vecs.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 2, 0, 8'h00, 0));
      vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 3, 0, 8'h01, 0));
      vecs.push_back(mk(0, 1, 8'h01, 1, 0, 0, 4, 0, 8'h02, 0));
      // start collides with valid: word 5 is dropped.
      vecs.push_back(mk(1, 1, 8'd5,  0, 0, 0, 0, 0, 8'd2,  0));
      vecs.push_back(mk(0, 1, 8'd20, 1, 0, 0, 0, 0, 8'd21, 0));
      vecs.push_back(mk(0, 1, 8'd21, 1, 0, 0, 1, 0, 8'd22, 0));
      // A match between misses clears the consecutive count: no resync.
      vecs.push_back(mk(0, 1, 8'h30, 1, 1, 1, 1, 1, 8'd23, 0));
      vecs.push_back(mk(0, 1, 8'h31, 1, 1, 1, 1, 2, 8'd24, 0));
      vecs.push_back(mk(0, 1, 8'd24, 1, 0, 1, 2, 2, 8'd25, 0));
      vecs.push_back(mk(0, 1, 8'h40, 1, 1, 1, 2, 3, 8'd26, 0));

      // Reset state.
      z = mk(0, 0, 8'd0, 0, 0, 0, 0, 0, 8'd0, 0);
      #2;
      chk_all(-1, z);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         apply(i, vecs[i]);

      // Reset mid-run: reach match_cnt=3, then pull reset between edges.
      apply(100, mk(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd26, 0));
      apply(101, mk(0, 1, 8'd0, 1, 0, 0, 0, 0, 8'd1,  0));
      apply(102, mk(0, 1, 8'd1, 1, 0, 0, 1, 0, 8'd2,  0));
      apply(103, mk(0, 1, 8'd2, 1, 0, 0, 2, 0, 8'd3,  0));
      apply(104, mk(0, 1, 8'd3, 1, 0, 0, 3, 0, 8'd4,  0));
      @(negedge clk);
      valid   = 1'b0;
      reset_n = 1'b0;
      #1;
      chk_all(105, z);
      @(negedge clk);
      reset_n = 1'b1;
      apply(106, mk(0, 1, 8'd4, 0, 0, 0, 0, 0, 8'd0, 0));
      apply(107, mk(0, 1, 8'd5, 0, 0, 0, 0, 0, 8'd0, 0));
      apply(108, mk(1, 0, 8'd0, 0, 0, 0, 0, 0, 8'd0, 0));
      apply(109, mk(0, 1, 8'd7, 1, 0, 0, 0, 0, 8'd8, 0));
      apply(110, mk(0, 1, 8'd8, 1, 0, 0, 1, 0, 8'd9, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
